// File: rtl/layernorm_matrix_scheduler_if.sv
// Bus between the layernorm matrix scheduler, its user and the external row engine.
// The slave modport is the scheduler side; master is the user plus row engine.
interface layernorm_matrix_scheduler_if #(
    parameter int DW   = 16,
    parameter int COLS = 16,
    parameter int ROWS = 16
);
    localparam int NW = $clog2(ROWS + 1);

    logic                    start;
    logic                    abort;
    logic [NW-1:0]           num_rows;
    logic [ROWS*COLS*DW-1:0] matrix_i;
    logic [ROWS*COLS*DW-1:0] matrix_o;
    logic                    pipe_valid_o;
    logic [COLS*DW-1:0]      pipe_row_o;
    logic                    pipe_valid_i;
    logic [COLS*DW-1:0]      pipe_row_i;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport slave (
        input  start, abort, num_rows, matrix_i, pipe_valid_i, pipe_row_i,
        output matrix_o, pipe_valid_o, pipe_row_o, busy, done, err
    );

    modport master (
        output start, abort, num_rows, matrix_i, pipe_valid_i, pipe_row_i,
        input  matrix_o, pipe_valid_o, pipe_row_o, busy, done, err
    );
endinterface

// File: rtl/layernorm_matrix_scheduler.sv
// Streams matrix rows to an external layernorm row engine and collects the
// normalised rows back into matrix_o; data passes through untouched.
module layernorm_matrix_scheduler #(
    parameter int DW      = 16,
    parameter int COLS    = 16,
    parameter int ROWS    = 16,
    parameter int TIMEOUT = 64
) (
    input logic                         clk,
    input logic                         rst_n,
    layernorm_matrix_scheduler_if.slave bus
);
    localparam int NW = $clog2(ROWS + 1);
    localparam int RW = COLS * DW;
    localparam int MW = ROWS * RW;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] nrows_q, nrows_d;
    logic [NW-1:0] sent_q, sent_d;
    logic [NW-1:0] rcvd_q, rcvd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pipe_valid_q, pipe_valid_d;
    logic [RW-1:0] pipe_row_q, pipe_row_d;
    logic [MW-1:0] mat_q, mat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic nrows_ok;
    logic pending;
    logic ret_acc;
    logic last_ret;
    logic tmo_hit;

    assign nrows_ok = (bus.num_rows != '0) && (int'(bus.num_rows) <= ROWS);
    // sent_q counts completed send cycles, so it equals the index of the row on pipe_row_o
    assign pending  = sent_q > rcvd_q;
    assign ret_acc  = (state_q == RUN) && bus.pipe_valid_i && (rcvd_q < nrows_q);
    assign last_ret = ret_acc && ((rcvd_q + NW'(1)) == nrows_q);
    assign tmo_hit  = (state_q == RUN) && !ret_acc && pending && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        nrows_d      = nrows_q;
        sent_d       = sent_q;
        rcvd_d       = rcvd_q;
        tmo_d        = tmo_q;
        pipe_valid_d = pipe_valid_q;
        pipe_row_d   = pipe_row_q;
        mat_d        = mat_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nrows_d = bus.num_rows;
                    sent_d  = '0;
                    rcvd_d  = '0;
                    tmo_d   = '0;
                    if (nrows_ok) begin
                        state_d      = RUN;
                        err_d        = 1'b0;
                        pipe_valid_d = 1'b1;
                        pipe_row_d   = bus.matrix_i[0 +: RW];
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // abort outranks any completion, timeout or write in the same cycle
                    state_d      = IDLE;
                    pipe_valid_d = 1'b0;
                end else begin
                    if (pipe_valid_q) begin
                        sent_d = sent_q + NW'(1);
                        if (int'(sent_q) + 1 < int'(nrows_q)) begin
                            pipe_row_d = bus.matrix_i[(int'(sent_q) + 1) * RW +: RW];
                        end else begin
                            pipe_valid_d = 1'b0;
                        end
                    end
                    if (ret_acc) begin
                        mat_d[int'(rcvd_q) * RW +: RW] = bus.pipe_row_i;
                        rcvd_d = rcvd_q + NW'(1);
                        tmo_d  = '0;
                    end else if (pending) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                    if (last_ret) begin
                        state_d = DONE;
                    end else if (tmo_hit) begin
                        state_d      = DONE;
                        err_d        = 1'b1;
                        pipe_valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                pipe_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            nrows_q      <= '0;
            sent_q       <= '0;
            rcvd_q       <= '0;
            tmo_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_row_q   <= '0;
            mat_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nrows_q      <= nrows_d;
            sent_q       <= sent_d;
            rcvd_q       <= rcvd_d;
            tmo_q        <= tmo_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_row_q   <= pipe_row_d;
            mat_q        <= mat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.matrix_o     = mat_q;
    assign bus.pipe_valid_o = pipe_valid_q;
    assign bus.pipe_row_o   = pipe_row_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule
